noise_tx_prbs: RTL and testbench
================================

# noise_tx_prbs

Transmit end of the noise-tester link. From the 50 MHz system clock it generates a PRBS-7 bit stream at a fixed bit period. With each bit it emits a bit-start strobe and a mid-bit strobe, so the downstream XOR/compare path samples each bit at its centre. It also outputs the uncorrupted reference bit, which the compare path uses as the expected data.

## Interface
- BIT_CYCLES, 250, clk cycles per transmitted bit (250 gives 200 kbit/s at 50 MHz); legal range 4..2047
- MID_OFFSET, 125, phase at which mid_strobe fires; must be < BIT_CYCLES
- BURST_BITS, 1024, bits per burst; 0 = continuous until stop
- clk  input  1  50 MHz system clock; all logic on posedge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  level sampled each cycle; begins a burst when idle
- stop  input  1  aborts a running burst
- seed  input  7  LFSR seed, latched on accepted start; 7'h00 is replaced by 7'h7F
- tx_bit  output  1  line bit to the device under test
- ref_bit  output  1  uncorrupted PRBS bit (expected value)
- bit_strobe  output  1  one-cycle pulse on the first cycle of each bit
- mid_strobe  output  1  one-cycle pulse at phase MID_OFFSET of each bit
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when a burst completes normally
- bits_sent  output  16  completed-bit count for the current or last burst

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - start=1 and stop=0: load lfsr=seed (or 7'h7F if seed is zero), phase=0, bits_sent=0, go to RUN.
  - stop=1 has priority over start; the block stays in IDLE.
- RUN
  - phase counts 0..BIT_CYCLES-1 and wraps.
  - ref_bit = lfsr[6].
  - At phase==BIT_CYCLES-1:
    - bits_sent increments and saturates at 16'hFFFF.
    - If BURST_BITS!=0 and the new count equals BURST_BITS, go to DONE.
    - Otherwise lfsr advances: lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]} (x^7+x^6+1).
  - stop=1: go to IDLE next cycle; no done pulse; bits_sent keeps its value.
  - start is ignored while in RUN.
- DONE: lasts one cycle with done=1 and busy=0, then IDLE; start is ignored in this cycle.
- Outside RUN: tx_bit=0, ref_bit=0, and both strobes are 0.
- bits_sent holds its final value until the next accepted start.
- Reset (rst_n=0 on a clock edge), including mid-burst:
  - State becomes IDLE.
  - All outputs go to 0, bits_sent=0, lfsr=7'h7F, phase=0.
  - Any pending inject is cleared.

## Timing
- Accepted start at edge T gives, from T+1:
  - busy=1, bit_strobe=1, and the first bit on tx_bit (seed[6]).
- bit_strobe is high when phase==0; mid_strobe is high when phase==MID_OFFSET.
- The first mid_strobe occurs at T+1+MID_OFFSET.
- A burst of N bits:
  - busy is high for N*BIT_CYCLES cycles.
  - done is high at T+1+N*BIT_CYCLES.
- tx_bit and ref_bit change only on bit_strobe cycles; there are no glitches within a bit.
- No output depends combinationally on any input.

## Configuration
- Macro NOISE_TX_INJECT_EN.
- When defined:
  - An extra input port inject (1 bit) exists.
  - A pulse on inject during RUN sets a pending flag. The next bit started after the pulse is transmitted inverted for the whole bit period: tx_bit = ref_bit ^ 1.
  - The flag clears at the end of that bit.
  - Multiple pulses before that bit starts still corrupt only one bit.
  - The LFSR and ref_bit are unaffected.
  - inject is ignored outside RUN.
- When undefined: no inject port, and tx_bit == ref_bit always.

## Test plan
- Reset with rst_n=0 for 3 cycles: all outputs 0, bits_sent=0, state IDLE.
- Set seed=7'h7F, BURST_BITS=8, start pulse at T:
  - Bits sampled on mid_strobe read 1,1,1,1,1,1,1,0.
  - done pulses at T+2001; bits_sent=8.
  - bit_strobe and mid_strobe are each seen 8 times, 125 cycles apart.
- Start with seed=0:
  - Stream is identical to seed=7'h7F.
  - Run continuous (BURST_BITS=0) for 254 bits: the sequence repeats with period 127.
- stop asserted at cycle 600 of a burst:
  - busy drops next cycle, no done pulse, bits_sent=2, tx_bit=0.
  - start and stop asserted together in IDLE: block stays idle.
- Reset mid-burst at cycle 1000: all outputs 0 on the next cycle; a subsequent start behaves as the fresh-start case.
- With NOISE_TX_INJECT_EN, pulse inject during bit 3:
  - Only bit 4 has tx_bit != ref_bit.
  - The ref_bit sequence is unchanged.
  - Two pulses within bit 3 still corrupt only bit 4.

Source files
------------

// File: rtl/noise_tx_prbs_if.sv
// Handshake and data bundle of the noise-tester transmit end.
// master drives start/stop/seed; slave is the PRBS transmitter.
interface noise_tx_prbs_if;
    logic        start;
    logic        stop;
    logic [6:0]  seed;
    logic        tx_bit;
    logic        ref_bit;
    logic        bit_strobe;
    logic        mid_strobe;
    logic        busy;
    logic        done;
    logic [15:0] bits_sent;

    modport master (
        output start, stop, seed,
        input  tx_bit, ref_bit, bit_strobe, mid_strobe, busy, done, bits_sent
    );

    modport slave (
        input  start, stop, seed,
        output tx_bit, ref_bit, bit_strobe, mid_strobe, busy, done, bits_sent
    );
endinterface

// File: rtl/noise_tx_prbs.sv
// PRBS-7 (x^7+x^6+1) bit-stream transmitter with bit-start and mid-bit strobes.
// Optional NOISE_TX_INJECT_EN adds an inject input that inverts one transmitted bit.
module noise_tx_prbs #(
    parameter int unsigned BIT_CYCLES = 250,
    parameter int unsigned MID_OFFSET = 125,
    parameter int unsigned BURST_BITS = 1024
) (
    input  logic clk,
    input  logic rst_n,
`ifdef NOISE_TX_INJECT_EN
    input  logic inject,
`endif
    noise_tx_prbs_if.slave bus
);

    localparam logic [10:0] PhaseLast = 11'(BIT_CYCLES - 1);
    localparam logic [10:0] PhaseMid  = 11'(MID_OFFSET);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [6:0]  lfsr_q, lfsr_d;
    logic [10:0] phase_q, phase_d;
    logic [15:0] sent_q, sent_d;
    logic        pend_q, pend_d;
    logic        inv_q, inv_d;
    logic        inject_in;
    logic        bit_end;
    logic [15:0] sent_inc;
    logic        run;

`ifdef NOISE_TX_INJECT_EN
    assign inject_in = inject;
`else
    assign inject_in = 1'b0;
`endif

    assign bit_end  = (phase_q == PhaseLast);
    assign sent_inc = (sent_q == 16'hFFFF) ? sent_q : sent_q + 16'd1;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        phase_d = phase_q;
        sent_d  = sent_q;
        pend_d  = pend_q;
        inv_d   = inv_q;
        case (state_q)
            StIdle: begin
                if (bus.start && !bus.stop) begin
                    state_d = StRun;
                    lfsr_d  = (bus.seed == 7'h00) ? 7'h7F : bus.seed;
                    phase_d = '0;
                    sent_d  = '0;
                    pend_d  = 1'b0;
                    inv_d   = 1'b0;
                end
            end
            StRun: begin
                if (bus.stop) begin
                    state_d = StIdle;
                    phase_d = '0;
                    pend_d  = 1'b0;
                    inv_d   = 1'b0;
                end else begin
                    phase_d = bit_end ? 11'd0 : phase_q + 11'd1;
                    if (inject_in) begin
                        pend_d = 1'b1;
                    end
                    if (bit_end) begin
                        sent_d = sent_inc;
                        // A pulse on the last cycle of a bit still targets the next bit.
                        inv_d  = pend_q | inject_in;
                        pend_d = 1'b0;
                        if ((BURST_BITS != 0) && (32'(sent_inc) == BURST_BITS)) begin
                            state_d = StDone;
                            phase_d = '0;
                            inv_d   = 1'b0;
                        end else begin
                            lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            lfsr_q  <= 7'h7F;
            phase_q <= '0;
            sent_q  <= '0;
            pend_q  <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            phase_q <= phase_d;
            sent_q  <= sent_d;
            pend_q  <= pend_d;
            inv_q   <= inv_d;
        end
    end

    // Outputs decode registered state only, so nothing follows the inputs combinationally.
    assign run            = (state_q == StRun);
    assign bus.busy       = run;
    assign bus.done       = (state_q == StDone);
    assign bus.ref_bit    = run & lfsr_q[6];
    assign bus.tx_bit     = run & (lfsr_q[6] ^ inv_q);
    assign bus.bit_strobe = run & (phase_q == 11'd0);
    assign bus.mid_strobe = run & (phase_q == PhaseMid);
    assign bus.bits_sent  = sent_q;

endmodule

// File: tb/tb_noise_tx_prbs.sv
// Bench for noise_tx_prbs: a burst instance and a fast continuous instance, both
// compared every cycle against a bit-index/phase arithmetic model.
module tb_noise_tx_prbs;

    localparam int BcA = 250;
    localparam int MidA = 125;
    localparam int BurstA = 8;
    localparam int BcC = 8;
    localparam int MidC = 3;
    localparam int BurstC = 0;
    localparam int CorrBits = 2048;
    // bit i holds the i-th transmitted bit for seed 7'h7F
    localparam logic [7:0] Seq7f = 8'b0111_1111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic inj_a = 1'b0;
    logic inj_c = 1'b0;

    always #10 clk = ~clk;

    noise_tx_prbs_if bus_a ();
    noise_tx_prbs_if bus_c ();

    noise_tx_prbs #(
        .BIT_CYCLES(BcA),
        .MID_OFFSET(MidA),
        .BURST_BITS(BurstA)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef NOISE_TX_INJECT_EN
        .inject(inj_a),
`endif
        .bus   (bus_a)
    );

    noise_tx_prbs #(
        .BIT_CYCLES(BcC),
        .MID_OFFSET(MidC),
        .BURST_BITS(BurstC)
    ) u_dut_c (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef NOISE_TX_INJECT_EN
        .inject(inj_c),
`endif
        .bus   (bus_c)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    logic [6:0] prbs_state [127];
    int         prbs_pos [128];

    bit         m_run [2];
    bit         m_done [2];
    int         m_k [2];
    int         m_sent [2];
    logic [6:0] m_seed [2];
    bit         m_corr [2][CorrBits];

    logic [21:0] act_a;
    logic [21:0] act_c;
    assign act_a = {bus_a.tx_bit, bus_a.ref_bit, bus_a.bit_strobe, bus_a.mid_strobe,
                    bus_a.busy, bus_a.done, bus_a.bits_sent};
    assign act_c = {bus_c.tx_bit, bus_c.ref_bit, bus_c.bit_strobe, bus_c.mid_strobe,
                    bus_c.busy, bus_c.done, bus_c.bits_sent};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void build_table();
        logic [6:0] s;
        s = 7'h7F;
        for (int j = 0; j < 127; j++) begin
            prbs_state[j] = s;
            prbs_pos[s] = j;
            s = {s[5:0], s[6] ^ s[5]};
        end
    endfunction

    function automatic int bc_of(input int i);
        return (i == 0) ? BcA : BcC;
    endfunction

    function automatic int mid_of(input int i);
        return (i == 0) ? MidA : MidC;
    endfunction

    function automatic int burst_of(input int i);
        return (i == 0) ? BurstA : BurstC;
    endfunction

    // Bit b of the m-sequence starting at state sd: the MSB of the state b steps on.
    function automatic logic prbs_bit(input logic [6:0] sd, input int b);
        logic [6:0] s;
        s = prbs_state[(prbs_pos[sd] + b) % 127];
        return s[6];
    endfunction

    function automatic void clear_corr(input int i);
        for (int j = 0; j < CorrBits; j++) m_corr[i][j] = 1'b0;
    endfunction

    task automatic model_step(input int i, input logic rs, input logic st, input logic sp,
                              input logic [6:0] sd, input logic inj);
        int b;
        int done_bits;
`ifndef NOISE_TX_INJECT_EN
        inj = 1'b0;
`endif
        if (!rs) begin
            m_run[i] = 1'b0;
            m_done[i] = 1'b0;
            m_k[i] = 0;
            m_sent[i] = 0;
            clear_corr(i);
        end else if (m_run[i]) begin
            if (sp) begin
                m_run[i] = 1'b0;
            end else begin
                b = m_k[i] / bc_of(i);
                if (inj && (b + 1 < CorrBits)) m_corr[i][b + 1] = 1'b1;
                m_k[i]++;
                if (m_k[i] % bc_of(i) == 0) begin
                    done_bits = m_k[i] / bc_of(i);
                    m_sent[i] = (done_bits > 65535) ? 65535 : done_bits;
                    if (burst_of(i) != 0 && done_bits == burst_of(i)) begin
                        m_run[i] = 1'b0;
                        m_done[i] = 1'b1;
                    end
                end
            end
        end else if (m_done[i]) begin
            m_done[i] = 1'b0;
        end else if (st && !sp) begin
            m_run[i] = 1'b1;
            m_k[i] = 0;
            m_sent[i] = 0;
            m_seed[i] = (sd == 7'h00) ? 7'h7F : sd;
            clear_corr(i);
        end
    endtask

    function automatic logic [21:0] model_out(input int i);
        int   b;
        int   ph;
        logic r;
        logic c;
        if (m_run[i]) begin
            b = m_k[i] / bc_of(i);
            ph = m_k[i] % bc_of(i);
            r = prbs_bit(m_seed[i], b);
            c = (b < CorrBits) ? m_corr[i][b] : 1'b0;
            return {r ^ c, r, ph == 0, ph == mid_of(i), 1'b1, 1'b0, 16'(m_sent[i])};
        end
        return {4'b0000, 1'b0, m_done[i], 16'(m_sent[i])};
    endfunction

    always @(posedge clk) begin
        cyc++;
        model_step(0, rst_n, bus_a.start, bus_a.stop, bus_a.seed, inj_a);
        model_step(1, rst_n, bus_c.start, bus_c.stop, bus_c.seed, inj_c);
        if (!rst_n) cmp_en = 1'b1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cycle_a", act_a, model_out(0));
            check("cycle_c", act_c, model_out(1));
        end
    end

    task automatic run_burst_a(input logic [6:0] sd, input int inj1, input int inj2,
                               output logic [7:0] txv, output logic [7:0] refv,
                               output int done_rel, output int n_bs, output int n_ms,
                               output int bad_gap, output int sent_end);
        int t0;
        int rel;
        int last_bs;
        txv = '0;
        refv = '0;
        done_rel = -1;
        n_bs = 0;
        n_ms = 0;
        bad_gap = 0;
        last_bs = -10000;
        @(posedge clk);
        #1;
        bus_a.seed = sd;
        bus_a.start = 1'b1;
        t0 = cyc + 1;
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        repeat (2100) begin
            @(negedge clk);
            rel = cyc - t0;
            inj_a = (rel == inj1 || rel == inj2);
            if (bus_a.bit_strobe) begin
                n_bs++;
                last_bs = rel;
            end
            if (bus_a.mid_strobe) begin
                if (rel - last_bs != MidA) bad_gap++;
                if (n_ms < 8) begin
                    txv[n_ms] = bus_a.tx_bit;
                    refv[n_ms] = bus_a.ref_bit;
                end
                n_ms++;
            end
            if (bus_a.done && done_rel < 0) done_rel = rel;
        end
        inj_a = 1'b0;
        sent_end = int'(bus_a.bits_sent);
    endtask

    task automatic fresh_burst(input string tag, input logic [6:0] sd);
        logic [7:0] txv;
        logic [7:0] refv;
        int done_rel, n_bs, n_ms, bad_gap, sent_end;
        run_burst_a(sd, -1, -1, txv, refv, done_rel, n_bs, n_ms, bad_gap, sent_end);
        check({tag, "_tx_seq"}, txv, Seq7f);
        check({tag, "_ref_seq"}, refv, Seq7f);
        check({tag, "_done_at"}, done_rel, 2000);
        check({tag, "_bits_sent"}, sent_end, 8);
        check({tag, "_n_bit_strobe"}, n_bs, 8);
        check({tag, "_n_mid_strobe"}, n_ms, 8);
        check({tag, "_mid_gap"}, bad_gap, 0);
    endtask

    task automatic run_cont_c();
        bit s [254];
        int n;
        int guard;
        logic [7:0] f;
        n = 0;
        guard = 0;
        @(posedge clk);
        #1;
        bus_c.seed = 7'h00;
        bus_c.start = 1'b1;
        @(posedge clk);
        #1;
        bus_c.start = 1'b0;
        while (n < 254 && guard < 254 * BcC + 50) begin
            @(negedge clk);
            guard++;
            if (bus_c.mid_strobe) begin
                s[n] = bus_c.tx_bit;
                n++;
            end
        end
        check("cont_bit_count", n, 254);
        @(posedge clk);
        #1;
        bus_c.stop = 1'b1;
        @(posedge clk);
        #1;
        bus_c.stop = 1'b0;
        for (int i = 0; i < 127; i++) check("cont_period127", s[i + 127], s[i]);
        for (int i = 0; i < 8; i++) f[i] = s[i];
        check("cont_seed0_head", f, Seq7f);
    endtask

    initial begin
        int t0;
        int rel;
        bit saw_done;
        build_table();
        bus_a.start = 1'b0;
        bus_a.stop = 1'b0;
        bus_a.seed = 7'h00;
        bus_c.start = 1'b0;
        bus_c.stop = 1'b0;
        bus_c.seed = 7'h00;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_outputs_a", act_a, 22'd0);
        check("reset_outputs_c", act_c, 22'd0);

        fresh_burst("seed7f", 7'h7F);
        fresh_burst("seed00", 7'h00);
        run_cont_c();

        // stop sampled on the 600th cycle of a burst
        @(posedge clk);
        #1;
        bus_a.seed = 7'h7F;
        bus_a.start = 1'b1;
        t0 = cyc + 1;
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        rel = 0;
        while (rel < 599) begin
            @(negedge clk);
            rel = cyc - t0;
        end
        bus_a.stop = 1'b1;
        @(negedge clk);
        bus_a.stop = 1'b0;
        check("stop_busy", bus_a.busy, 1'b0);
        check("stop_bits_sent", bus_a.bits_sent, 16'd2);
        check("stop_tx_bit", bus_a.tx_bit, 1'b0);
        saw_done = bus_a.done;
        repeat (5) begin
            @(negedge clk);
            saw_done = saw_done | bus_a.done;
        end
        check("stop_no_done", saw_done, 1'b0);

        // start and stop together while idle
        @(posedge clk);
        #1;
        bus_a.start = 1'b1;
        bus_a.stop = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("start_stop_idle", bus_a.busy, 1'b0);
        end
        bus_a.start = 1'b0;
        bus_a.stop = 1'b0;

        // reset sampled on the 1000th cycle of a burst
        @(posedge clk);
        #1;
        bus_a.seed = 7'h15;
        bus_a.start = 1'b1;
        t0 = cyc + 1;
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        rel = 0;
        while (rel < 999) begin
            @(negedge clk);
            rel = cyc - t0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_outputs_a", act_a, 22'd0);
        fresh_burst("after_reset", 7'h7F);

`ifdef NOISE_TX_INJECT_EN
        begin
            logic [7:0] txv;
            logic [7:0] refv;
            int done_rel, n_bs, n_ms, bad_gap, sent_end;
            run_burst_a(7'h7F, 800, -1, txv, refv, done_rel, n_bs, n_ms, bad_gap, sent_end);
            check("inject1_ref_seq", refv, Seq7f);
            check("inject1_diff", txv ^ refv, 8'b0001_0000);
            run_burst_a(7'h7F, 800, 900, txv, refv, done_rel, n_bs, n_ms, bad_gap, sent_end);
            check("inject2_ref_seq", refv, Seq7f);
            check("inject2_diff", txv ^ refv, 8'b0001_0000);
        end
`endif

        // randomized traffic on both instances; the per-cycle compare does the checking
        repeat (12000) begin
            @(posedge clk);
            #1;
            rst_n = ($urandom_range(0, 4999) != 0);
            bus_a.start = ($urandom_range(0, 99) < 3);
            bus_a.stop = ($urandom_range(0, 1499) == 0);
            bus_a.seed = ($urandom_range(0, 7) == 0) ? 7'h00 : 7'($urandom);
            inj_a = ($urandom_range(0, 199) == 0);
            bus_c.start = ($urandom_range(0, 19) == 0);
            bus_c.stop = ($urandom_range(0, 199) == 0) || (m_k[1] > 4000);
            bus_c.seed = ($urandom_range(0, 7) == 0) ? 7'h00 : 7'($urandom);
            inj_c = ($urandom_range(0, 15) == 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_a.start = 1'b0;
        bus_a.stop = 1'b0;
        bus_c.start = 1'b0;
        bus_c.stop = 1'b0;
        inj_a = 1'b0;
        inj_c = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
